// File: rtl/line_window_gen_if.sv
// Pixel-stream bundle for line_window_gen: raw video in, windowed video out.
// master drives the video inputs; slave (the window generator) drives the results.
interface line_window_gen_if #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3
);
  logic [DATA_W-1:0]             data_in;
  logic                          de_in;
  logic                          hsync_in;
  logic                          vsync_in;
  logic [KSIZE*KSIZE*DATA_W-1:0] win_out;
  logic                          win_valid;
  logic                          de_out;
  logic                          hsync_out;
  logic                          vsync_out;
  logic                          ovf_err;

  modport master (
    output data_in, de_in, hsync_in, vsync_in,
    input  win_out, win_valid, de_out, hsync_out, vsync_out, ovf_err
  );

  modport slave (
    input  data_in, de_in, hsync_in, vsync_in,
    output win_out, win_valid, de_out, hsync_out, vsync_out, ovf_err
  );
endinterface

// File: rtl/line_window_gen.sv
// KSIZE x KSIZE sliding-window generator: KSIZE-1 chained line RAMs plus
// per-row horizontal shift taps, with syncs delayed to match (latency 2).
// Optional macro WIN_ZERO_PAD_EN: zero-pad border taps and flag every active
// pixel valid; when undefined only full windows are flagged valid.
module line_window_gen #(
  parameter int DATA_W   = 8,
  parameter int KSIZE    = 3,
  parameter int LINE_MAX = 128
) (
  input logic              pclk,
  input logic              rst,
  line_window_gen_if.slave bus
);
  localparam int AW = $clog2(LINE_MAX);
  localparam int NR = KSIZE - 1;
  localparam int CW = $clog2(KSIZE);
  localparam logic [AW-1:0] COL_LAST = AW'(LINE_MAX - 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(KSIZE - 1);

  typedef logic [DATA_W-1:0] pix_t;

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("line_window_gen: KSIZE must be 3 or 5");
  end

  logic [AW-1:0] r_col, r_col_d1;
  logic          r_line_full, r_de_prev, r_vs_prev, r_ovf;
  logic [CW-1:0] r_rows, r_rows_d1, r_rows_win, r_cols;
  pix_t          r_pix_d1;
  logic          r_we_d1, r_de_d1, r_hs_d1, r_vs_d1;
  logic          r_de_out, r_hs_out, r_vs_out;
  pix_t          r_taps [KSIZE][KSIZE];
  pix_t          w_rd [NR];
  pix_t          w_wr [NR];
  logic          w_vs_rise, w_de_fall, w_at_last, w_ovf_hit;

  assign w_vs_rise = bus.vsync_in & ~r_vs_prev;
  assign w_de_fall = ~bus.de_in & r_de_prev;
  assign w_at_last = (r_col == COL_LAST);
  // r_line_full marks that column LINE_MAX-1 was already written this line,
  // so a second pixel at the held column is the first overflowing one
  assign w_ovf_hit = bus.de_in & w_at_last & r_line_full;

  // Writes are issued one cycle after the read (from stage-1 registers) so
  // RAM k can take RAM k-1's registered read data; the address never
  // collides with the current read except while overflowing, when writes stop.
  for (genvar k = 0; k < NR; k++) begin : g_ram
    pix_t r_ram [LINE_MAX];
    pix_t r_rd;
    if (k == 0) begin : g_src
      assign w_wr[k] = r_pix_d1;
    end else begin : g_src
      assign w_wr[k] = w_rd[k-1];
    end
    // One line of storage with registered read, returning the pixel one line older
    always_ff @(posedge pclk) begin
      if (r_we_d1) r_ram[r_col_d1] <= w_wr[k];
      if (rst) r_rd <= '0;
      else     r_rd <= r_ram[r_col];
    end
    assign w_rd[k] = r_rd;
  end

  // Column/row bookkeeping, overflow flag and the first pipeline stage
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_col       <= '0;
      r_line_full <= 1'b0;
      r_de_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
      r_rows      <= '0;
      r_ovf       <= 1'b0;
      r_pix_d1    <= '0;
      r_col_d1    <= '0;
      r_we_d1     <= 1'b0;
      r_de_d1     <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_vs_d1     <= 1'b0;
      r_rows_d1   <= '0;
    end else begin
      r_de_prev <= bus.de_in;
      r_vs_prev <= bus.vsync_in;
      if (!bus.de_in)     r_col <= '0;
      else if (!w_at_last) r_col <= r_col + AW'(1);
      r_line_full <= bus.de_in & (r_line_full | w_at_last);
      if (w_vs_rise)                          r_rows <= '0;
      else if (w_de_fall && r_rows != FILL_MAX) r_rows <= r_rows + CW'(1);
      if (w_vs_rise)      r_ovf <= 1'b0;
      else if (w_ovf_hit) r_ovf <= 1'b1;
      r_pix_d1  <= bus.data_in;
      r_col_d1  <= r_col;
      r_we_d1   <= bus.de_in & ~r_line_full;
      r_de_d1   <= bus.de_in;
      r_hs_d1   <= bus.hsync_in;
      r_vs_d1   <= bus.vsync_in;
      r_rows_d1 <= r_rows;
    end
  end

  // Window register: horizontal shift taps and output-aligned syncs/fill counts
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned c = 0; c < KSIZE; c++)
          r_taps[r][c] <= '0;
      r_de_out   <= 1'b0;
      r_hs_out   <= 1'b0;
      r_vs_out   <= 1'b0;
      r_rows_win <= '0;
      r_cols     <= '0;
    end else begin
      if (r_de_d1) begin
        for (int unsigned r = 0; r < KSIZE; r++)
          for (int unsigned c = 0; c < NR; c++)
            r_taps[r][c] <= r_taps[r][c+1];
        for (int unsigned r = 0; r < NR; r++)
          r_taps[r][NR] <= w_rd[NR-1-r];
        r_taps[NR][NR] <= r_pix_d1;
      end
      r_de_out   <= r_de_d1;
      r_hs_out   <= r_hs_d1;
      r_vs_out   <= r_vs_d1;
      r_rows_win <= r_rows_d1;
      if (!r_de_d1 || !r_de_out) r_cols <= '0;
      else if (r_cols != FILL_MAX) r_cols <= r_cols + CW'(1);
    end
  end

  // Flatten taps onto the output bus, zeroing unfilled border taps when padding
  always_comb begin
    bus.win_out = '0;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE; c++) begin
`ifdef WIN_ZERO_PAD_EN
        if ((int'(r) + int'(r_rows_win) < NR) || (int'(c) + int'(r_cols) < NR))
          bus.win_out[(r*KSIZE+c)*DATA_W +: DATA_W] = '0;
        else
          bus.win_out[(r*KSIZE+c)*DATA_W +: DATA_W] = r_taps[r][c];
`else
        bus.win_out[(r*KSIZE+c)*DATA_W +: DATA_W] = r_taps[r][c];
`endif
      end
    end
  end

`ifdef WIN_ZERO_PAD_EN
  assign bus.win_valid = r_de_out;
`else
  assign bus.win_valid = r_de_out & (r_rows_win == FILL_MAX) & (r_cols == FILL_MAX);
`endif
  assign bus.de_out    = r_de_out;
  assign bus.hsync_out = r_hs_out;
  assign bus.vsync_out = r_vs_out;
  assign bus.ovf_err   = r_ovf;
endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: a line-array reference model predicts every
// window from the frame geometry; outputs are checked each cycle.
module tb_line_window_gen;
`ifdef WIN_ZERO_PAD_EN
  localparam int  K   = 5;
  localparam bit  PAD = 1'b1;
`else
  localparam int  K   = 3;
  localparam bit  PAD = 1'b0;
`endif
  localparam int DW = 8;
  localparam int LM = 128;
  localparam int NT = K * K;
  localparam int LX = LM + 8;

  typedef struct packed {
    logic rs, de, hs, vs;
    logic [DW-1:0] d;
  } stim_t;

  typedef struct packed {
    logic de, hs, vs, valid, chk;
    logic [DW-1:0]    newest;
    logic [NT*DW-1:0] win;
  } exp_t;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  line_window_gen_if #(.DATA_W(DW), .KSIZE(K)) bus ();
  line_window_gen #(.DATA_W(DW), .KSIZE(K), .LINE_MAX(LM)) dut (
    .pclk(pclk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: m_line[a][x] = pixel x of the line a lines ago (a=0 current)
  logic [DW-1:0] m_line [K][LX];
  int   m_col, m_rows;
  logic m_pde, m_pvs, m_ovf;
  exp_t q[$];
  stim_t sq[$];

  function automatic stim_t mk(logic rs, logic de, logic hs, logic vs, logic [DW-1:0] d);
    mk = {rs, de, hs, vs, d};
  endfunction

  function automatic logic [DW-1:0] pix(int mode, int ln, int c);
    if (mode == 0) return DW'(16 * ln + c);
    if (mode == 1) return 8'hFF;
    return DW'($urandom);
  endfunction

  function automatic void add_idle(int n);
    repeat (n) sq.push_back(mk(0, 0, 0, 0, '0));
  endfunction

  function automatic void add_vsync();
    sq.push_back(mk(0, 0, 0, 1, '0));
    sq.push_back(mk(0, 0, 0, 1, '0));
    add_idle(2);
  endfunction

  function automatic void add_line(int ln, int w, int mode, bit rst_last);
    sq.push_back(mk(0, 0, 1, 0, '0));
    add_idle(1);
    for (int c = 0; c < w; c++)
      sq.push_back(mk(rst_last && (c == w - 1), 1, 0, 0, pix(mode, ln, c)));
  endfunction

  // drive one cycle and advance the model; leaves outputs of the previous input at the head of q
  task automatic step(input stim_t s);
    exp_t e;
    int c, a, x;
    logic [DW-1:0] v;
    bus.data_in  = s.d;
    bus.de_in    = s.de;
    bus.hsync_in = s.hs;
    bus.vsync_in = s.vs;
    rst          = s.rs;
    if (s.rs) begin
      @(posedge pclk); #1;
      rst = 1'b0;
      q.delete();
      m_rows = 0; m_col = 0; m_pde = 0; m_pvs = 0; m_ovf = 0;
      q.push_back('0);
      return;
    end
    c = m_col;
    if (s.de && c < LX) m_line[0][c] = s.d;
    e = '0;
    e.de = s.de; e.hs = s.hs; e.vs = s.vs; e.newest = s.d;
    for (int r = 0; r < K; r++) begin
      for (int cc = 0; cc < K; cc++) begin
        a = K - 1 - r;
        x = c - (K - 1 - cc);
        v = (x >= 0 && x < LX && a <= m_rows) ? m_line[a][x] : '0;
        e.win[(r*K+cc)*DW +: DW] = v;
      end
    end
    e.valid = PAD ? s.de : (s.de && m_rows == K - 1 && c >= K - 1);
    e.chk   = e.valid;
    if (s.de) m_col++;
    if (s.vs && !m_pvs)   m_ovf = 1'b0;
    else if (s.de && c >= LM) m_ovf = 1'b1;
    if (!s.de && m_pde) begin
      for (int i = K - 1; i > 0; i--) m_line[i] = m_line[i-1];
      if (m_rows < K - 1) m_rows++;
    end
    if (s.vs && !m_pvs) m_rows = 0;
    if (!s.de) m_col = 0;
    m_pde = s.de;
    m_pvs = s.vs;
    q.push_back(e);
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    stim_t s;
    sq.delete();
    for (int i = 0; i < 3; i++) sq.push_back(mk(1, 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom)));
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if ({bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid, bus.ovf_err, bus.win_out} !== '0) begin
        bad++;
        $display("FAIL reset outputs got=%h required=0",
                 {bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid, bus.ovf_err, bus.win_out});
      end
    end
  endtask

  task automatic test_frame_pattern();
    stim_t s; exp_t e;
    sq.delete();
    add_vsync();
    for (int ln = 0; ln < 6; ln++) add_line(ln, 8, 0, 0);
    add_idle(4);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      e = q.pop_front();
      total++;
      if ({bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid} !== {e.de, e.hs, e.vs, e.valid}) begin
        bad++;
        $display("FAIL pattern ctl got=%b required=%b",
                 {bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid}, {e.de, e.hs, e.vs, e.valid});
      end
      if (e.chk) begin
        total++;
        if (bus.win_out !== e.win) begin
          bad++;
          $display("FAIL pattern window got=%h required=%h", bus.win_out, e.win);
        end
      end
    end
  endtask

  task automatic test_latency();
    stim_t s; exp_t e;
    int pulse_at, seen_cyc;
    sq.delete();
    add_idle(9);
    sq.push_back(mk(0, 1, 1, 1, DW'($urandom)));
    add_idle(5);
    pulse_at = 9;
    seen_cyc = -1;
    for (int i = 0; sq.size() > 0; i++) begin
      s = sq.pop_front();
      step(s);
      e = q.pop_front();
      // outputs observed after step i are those of cycle i+1
      if (bus.de_out === 1'b1 && seen_cyc < 0) seen_cyc = i + 1;
      total++;
      if ({bus.de_out, bus.hsync_out, bus.vsync_out} !== {e.de, e.hs, e.vs}) begin
        bad++;
        $display("FAIL latency syncs got=%b required=%b",
                 {bus.de_out, bus.hsync_out, bus.vsync_out}, {e.de, e.hs, e.vs});
      end
      if (e.de) begin
        total++;
        if (bus.win_out[NT*DW-1 -: DW] !== e.newest) begin
          bad++;
          $display("FAIL latency data got=%h required=%h", bus.win_out[NT*DW-1 -: DW], e.newest);
        end
      end
    end
    total++;
    if (seen_cyc - pulse_at != 2) begin
      bad++;
      $display("FAIL latency cycles got=%0d required=2", seen_cyc - pulse_at);
    end
  endtask

  task automatic test_overflow();
    stim_t s; exp_t e;
    sq.delete();
    add_vsync();
    add_line(0, LM + 2, 2, 0);
    add_line(1, LM, 2, 0);
    add_line(2, LM, 2, 0);
    add_vsync();
    add_idle(2);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      e = q.pop_front();
      total++;
      if (bus.ovf_err !== m_ovf) begin
        bad++;
        $display("FAIL overflow flag got=%b required=%b", bus.ovf_err, m_ovf);
      end
      total++;
      if ({bus.de_out, bus.win_valid} !== {e.de, e.valid}) begin
        bad++;
        $display("FAIL overflow ctl got=%b required=%b", {bus.de_out, bus.win_valid}, {e.de, e.valid});
      end
      if (e.chk) begin
        total++;
        if (bus.win_out !== e.win) begin
          bad++;
          $display("FAIL overflow window got=%h required=%h", bus.win_out, e.win);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    stim_t s; exp_t e;
    sq.delete();
    add_vsync();
    for (int ln = 0; ln < 7; ln++) add_line(ln, 8, 2, ln == 3);
    add_idle(4);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      if (s.rs) begin
        total++;
        if ({bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid, bus.ovf_err, bus.win_out} !== '0) begin
          bad++;
          $display("FAIL midreset outputs got=%h required=0",
                   {bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid, bus.ovf_err, bus.win_out});
        end
      end else begin
        e = q.pop_front();
        total++;
        if ({bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid} !== {e.de, e.hs, e.vs, e.valid}) begin
          bad++;
          $display("FAIL midreset ctl got=%b required=%b",
                   {bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid}, {e.de, e.hs, e.vs, e.valid});
        end
        if (e.chk) begin
          total++;
          if (bus.win_out !== e.win) begin
            bad++;
            $display("FAIL midreset window got=%h required=%h", bus.win_out, e.win);
          end
        end
      end
    end
  endtask

  task automatic test_two_frames();
    stim_t s; exp_t e;
    int w;
    sq.delete();
    for (int f = 0; f < 2; f++) begin
      w = $urandom_range(K + 2, 12);
      add_vsync();
      for (int ln = 0; ln < 4; ln++) add_line(ln, w, 2, 0);
    end
    add_idle(4);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      e = q.pop_front();
      total++;
      if ({bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid} !== {e.de, e.hs, e.vs, e.valid}) begin
        bad++;
        $display("FAIL frames ctl got=%b required=%b",
                 {bus.de_out, bus.hsync_out, bus.vsync_out, bus.win_valid}, {e.de, e.hs, e.vs, e.valid});
      end
      if (e.chk) begin
        total++;
        if (bus.win_out !== e.win) begin
          bad++;
          $display("FAIL frames window got=%h required=%h", bus.win_out, e.win);
        end
      end
    end
  endtask

`ifdef WIN_ZERO_PAD_EN
  task automatic test_zero_pad();
    stim_t s; exp_t e;
    sq.delete();
    add_vsync();
    for (int ln = 0; ln < 6; ln++) add_line(ln, 8, 1, 0);
    add_idle(4);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      e = q.pop_front();
      total++;
      if ({bus.de_out, bus.win_valid} !== {e.de, e.valid}) begin
        bad++;
        $display("FAIL zeropad ctl got=%b required=%b", {bus.de_out, bus.win_valid}, {e.de, e.valid});
      end
      if (e.chk) begin
        total++;
        if (bus.win_out !== e.win) begin
          bad++;
          $display("FAIL zeropad window got=%h required=%h", bus.win_out, e.win);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.data_in  = '0;
    bus.de_in    = 1'b0;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    test_reset();
    test_frame_pattern();
    test_latency();
    test_overflow();
    test_mid_reset();
    test_two_frames();
`ifdef WIN_ZERO_PAD_EN
    test_zero_pad();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
